scan_test_sequencer: RTL and testbench
======================================

Name: scan_test_sequencer

Overview:
- On-chip sequencer for the CORE alarm-clock scan chain. It replays stored ATPG patterns through TEST_MODE/TEST_SE/TEST_SI and compares TEST_SO against masked expected responses.
- Sits between a pattern ROM (combinational lookup via index outputs) and the CORE scan ports.
- Reports pass/fail, error count and first failing pattern, enabling self-test without the external tester bench.

Parameters:
- CHAIN_LEN, 30, scan chain length in flops (>=2).
- CNT_W, 5, bit-index width; 2**CNT_W >= CHAIN_LEN.
- PAT_W, 8, pattern-index width.
- ERR_W, 8, error-counter width.

Ports:
- CLOCK  in  1  single system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  start request, sampled in IDLE or DONE only.
- ABORT  in  1  abandon the run and return to IDLE.
- NUM_PAT  in  PAT_W  pattern count, latched on accepted START.
- LD_PAT_IDX  out  PAT_W  ROM index of the pattern being loaded.
- UL_PAT_IDX  out  PAT_W  ROM index of the response being unloaded (LD_PAT_IDX-1; equals NUM_PAT-1 in UNLOAD).
- BIT_IDX  out  CNT_W  current shift position, 0..CHAIN_LEN-1.
- LOAD_BIT  in  1  ROM load bit for (LD_PAT_IDX, BIT_IDX), same cycle.
- EXP_BIT  in  1  ROM expected bit for (UL_PAT_IDX, BIT_IDX), same cycle.
- MASK_BIT  in  1  1 = don't-care for (UL_PAT_IDX, BIT_IDX).
- TEST_MODE  out  1  to CORE.
- TEST_SE  out  1  to CORE.
- TEST_SI  out  1  to CORE.
- TEST_SO  in  1  chain output from CORE.
- BUSY  out  1  run in progress.
- DONE  out  1  run finished; held until next START or reset.
- FAIL  out  1  at least one unmasked miscompare occurred.
- ERR_COUNT  out  ERR_W  unmasked miscompares, saturating at all-ones.
- FIRST_FAIL_PAT  out  PAT_W  UL_PAT_IDX of the first miscompare.

Behaviour:
- Reset: FSM = IDLE. All outputs 0, including indices, counters and FIRST_FAIL_PAT. Reset mid-run abandons immediately, with no partial status retained.
- All outputs are registered except TEST_SI.
  - TEST_SI = LOAD_BIT when in SHIFT, else 0.
- States: IDLE, SETUP, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE/DONE + START:
  - Latch NUM_PAT; clear ERR_COUNT, FAIL, FIRST_FAIL_PAT and DONE; set BUSY.
  - If NUM_PAT = 0, go directly to DONE with FAIL = 0 and BUSY asserted for 1 cycle.
  - Otherwise go to SETUP.
- SETUP (1 cycle): TEST_MODE = 1, TEST_SE = 0, LD_PAT_IDX = 0, BIT_IDX = 0. Then go to SHIFT.
- SHIFT (CHAIN_LEN cycles): TEST_SE = 1, BIT_IDX increments 0..CHAIN_LEN-1.
  - If LD_PAT_IDX > 0, compare each cycle: TEST_SO vs EXP_BIT unless MASK_BIT.
  - After the last bit, go to CAPTURE.
- CAPTURE (1 cycle): TEST_SE = 0 (the CORE captures on this edge). BIT_IDX = 0; LD_PAT_IDX increments.
  - If the new LD_PAT_IDX = NUM_PAT, go to UNLOAD; else go to SHIFT.
- UNLOAD (CHAIN_LEN cycles): TEST_SE = 1, TEST_SI = 0, compare as in SHIFT. Then go to DONE.
- DONE: TEST_MODE = 0, TEST_SE = 0, BUSY = 0, DONE = 1. Status holds.
- Run length: BUSY is high for exactly 1 + NUM_PAT*(CHAIN_LEN+1) + CHAIN_LEN cycles (NUM_PAT > 0).
- Miscompare handling:
  - ERR_COUNT increments on the next edge, saturating.
  - FAIL sets on the next edge.
  - FIRST_FAIL_PAT is written only when FAIL was 0 before that edge.
- ABORT (any non-IDLE state): go to IDLE next edge. TEST_MODE, TEST_SE, BUSY and DONE go to 0; error status holds. ABORT has priority over START.
- START while BUSY is ignored.
- LD_PAT_IDX arithmetic is modulo 2**PAT_W. NUM_PAT up to 2**PAT_W-1 is legal.

Test Plan:
- Reset mid-SHIFT (assert RESET at BUSY cycle 10) -> all outputs 0 asynchronously; a subsequent START runs normally.
- CHAIN_LEN = 30, NUM_PAT = 2, golden CORE model, no masks -> BUSY high 93 cycles, DONE = 1, FAIL = 0, ERR_COUNT = 0. TEST_SE low exactly on cycles 32 and 63 of the run.
- NUM_PAT = 3, one EXP_BIT flipped (pattern 1, bit 7) -> FAIL = 1, ERR_COUNT = 1, FIRST_FAIL_PAT = 1. Same flip with MASK_BIT = 1 -> FAIL = 0.
- Stuck-at-1 TEST_SO, NUM_PAT = 20, all-zero expected, ERR_W = 8 -> ERR_COUNT saturates at 255, FIRST_FAIL_PAT = 0.
- NUM_PAT = 0 -> DONE one cycle after START, TEST_MODE never high. START pulsed during BUSY -> ignored, cycle count unchanged.
- ABORT in CAPTURE of pattern 1 -> IDLE next edge, TEST_MODE = 0, DONE = 0; a new START clears status and the rerun passes.

Source files
------------

// File: rtl/scan_test_sequencer_if.sv
// Scan sequencer signal bundle: run control, status, pattern ROM lookup and
// CORE scan pins. The master view belongs to the sequencer. The slave view
// belongs to the host/ROM/CORE environment.
interface scan_test_sequencer_if #(
  parameter int CNT_W = 5,
  parameter int PAT_W = 8,
  parameter int ERR_W = 8
);
  // run control and status
  logic             START;
  logic             ABORT;
  logic [PAT_W-1:0] NUM_PAT;
  logic             BUSY;
  logic             DONE;
  logic             FAIL;
  logic [ERR_W-1:0] ERR_COUNT;
  logic [PAT_W-1:0] FIRST_FAIL_PAT;
  // pattern ROM lookup
  logic [PAT_W-1:0] LD_PAT_IDX;
  logic [PAT_W-1:0] UL_PAT_IDX;
  logic [CNT_W-1:0] BIT_IDX;
  logic             LOAD_BIT;
  logic             EXP_BIT;
  logic             MASK_BIT;
  // CORE scan pins
  logic             TEST_MODE;
  logic             TEST_SE;
  logic             TEST_SI;
  logic             TEST_SO;

  modport master (
    input  START, ABORT, NUM_PAT, LOAD_BIT, EXP_BIT, MASK_BIT, TEST_SO,
    output BUSY, DONE, FAIL, ERR_COUNT, FIRST_FAIL_PAT,
           LD_PAT_IDX, UL_PAT_IDX, BIT_IDX, TEST_MODE, TEST_SE, TEST_SI
  );

  modport slave (
    output START, ABORT, NUM_PAT, LOAD_BIT, EXP_BIT, MASK_BIT, TEST_SO,
    input  BUSY, DONE, FAIL, ERR_COUNT, FIRST_FAIL_PAT,
           LD_PAT_IDX, UL_PAT_IDX, BIT_IDX, TEST_MODE, TEST_SE, TEST_SI
  );
endinterface

// File: rtl/scan_test_sequencer.sv
// On-chip scan test sequencer. It replays stored patterns into the CORE scan
// chain. While the next pattern shifts in, it compares the previous captured
// response against the masked expected bits from the ROM.
module scan_test_sequencer #(
  parameter int CHAIN_LEN = 30,
  parameter int CNT_W     = 5,
  parameter int PAT_W     = 8,
  parameter int ERR_W     = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  scan_test_sequencer_if.master scan
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] num_pat;
  logic [PAT_W-1:0] ld_idx;
  logic [PAT_W-1:0] ul_idx;
  logic [CNT_W-1:0] bit_idx;
  logic             test_mode;
  logic             test_se;
  logic             busy;
  logic             done;
  logic             fail;
  logic [ERR_W-1:0] err_count;
  logic [PAT_W-1:0] first_fail;

  logic             last_bit;
  logic [PAT_W-1:0] ld_next;
  logic             cmp_en;
  logic             miscompare;

  // Decode the shift position, the next pattern index and the compare qualifier.
  // Responses exist only after the first capture, so no compare happens while pattern 0 shifts in.
  always_comb begin
    last_bit   = (bit_idx == CNT_W'(CHAIN_LEN - 1));
    ld_next    = ld_idx + PAT_W'(1);
    cmp_en     = ((state == S_SHIFT) && (ld_idx != '0)) || (state == S_UNLOAD);
    miscompare = cmp_en && !scan.MASK_BIT && (scan.TEST_SO != scan.EXP_BIT);
  end

  // Sequencer FSM, with registered scan controls, indices and error status.
  // For a zero-length run, the FSM enters DONE with BUSY still set. It then
  // swaps BUSY for DONE one cycle later, so BUSY shows a single-cycle pulse.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      num_pat    <= '0;
      ld_idx     <= '0;
      ul_idx     <= '0;
      bit_idx    <= '0;
      test_mode  <= 1'b0;
      test_se    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else if (scan.ABORT && (state != S_IDLE)) begin
      state     <= S_IDLE;
      bit_idx   <= '0;
      test_mode <= 1'b0;
      test_se   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (miscompare) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        fail <= 1'b1;
        if (!fail) first_fail <= ul_idx;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if ((state == S_DONE) && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (scan.START && !scan.ABORT) begin
            num_pat    <= scan.NUM_PAT;
            err_count  <= '0;
            fail       <= 1'b0;
            first_fail <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            ld_idx     <= '0;
            ul_idx     <= '1;
            bit_idx    <= '0;
            test_se    <= 1'b0;
            if (scan.NUM_PAT == '0) begin
              state     <= S_DONE;
              test_mode <= 1'b0;
            end else begin
              state     <= S_SETUP;
              test_mode <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          state   <= S_SHIFT;
          test_se <= 1'b1;
        end

        S_SHIFT: begin
          if (last_bit) begin
            state   <= S_CAPTURE;
            test_se <= 1'b0;
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          ld_idx  <= ld_next;
          ul_idx  <= ld_idx;
          bit_idx <= '0;
          test_se <= 1'b1;
          state   <= (ld_next == num_pat) ? S_UNLOAD : S_SHIFT;
        end

        S_UNLOAD: begin
          if (last_bit) begin
            state     <= S_DONE;
            bit_idx   <= '0;
            test_mode <= 1'b0;
            test_se   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            bit_idx <= bit_idx + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Drive the registered outputs. Scan-in is the only combinational output.
  // It passes the ROM load bit through only while a pattern shifts in.
  assign scan.LD_PAT_IDX     = ld_idx;
  assign scan.UL_PAT_IDX     = ul_idx;
  assign scan.BIT_IDX        = bit_idx;
  assign scan.TEST_MODE      = test_mode;
  assign scan.TEST_SE        = test_se;
  assign scan.TEST_SI        = (state == S_SHIFT) ? scan.LOAD_BIT : 1'b0;
  assign scan.BUSY           = busy;
  assign scan.DONE           = done;
  assign scan.FAIL           = fail;
  assign scan.ERR_COUNT      = err_count;
  assign scan.FIRST_FAIL_PAT = first_fail;

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Directed bench for scan_test_sequencer. It includes a small pattern ROM and
// a golden CORE chain. The CORE captures by inverting the chain, so each
// pattern's expected response is the bitwise inverse of its load bits.
module tb_scan_test_sequencer;

  localparam int L = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  scan_test_sequencer_if #(.CNT_W(5), .PAT_W(8), .ERR_W(8)) sif ();

  scan_test_sequencer #(.CHAIN_LEN(L), .CNT_W(5), .PAT_W(8), .ERR_W(8)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .scan  (sif)
  );

  always #5 clk = ~clk;

  // Fault controls for the ROM and the CORE model.
  logic       stuck   = 1'b0;
  logic       flip_en = 1'b0;
  logic       mask_en = 1'b0;
  logic [7:0] flip_pat = 8'd0;
  logic [4:0] flip_bit = 5'd0;
  logic       hit;

  function automatic logic lb(input logic [7:0] p, input logic [4:0] k);
    return p[0] ^ k[0] ^ k[2] ^ (p[1] & k[3]);
  endfunction

  // Pattern ROM.
  assign hit          = (sif.UL_PAT_IDX == flip_pat) && (sif.BIT_IDX == flip_bit);
  assign sif.LOAD_BIT = lb(sif.LD_PAT_IDX, sif.BIT_IDX);
  assign sif.EXP_BIT  = stuck ? 1'b0 : (~lb(sif.UL_PAT_IDX, sif.BIT_IDX) ^ (flip_en & hit));
  assign sif.MASK_BIT = mask_en & hit;

  // Golden CORE chain.
  logic [L-1:0] chain = '0;
  always_ff @(posedge clk) begin
    if (sif.TEST_SE)        chain <= {chain[L-2:0], sif.TEST_SI};
    else if (sif.TEST_MODE) chain <= ~chain;
  end
  assign sif.TEST_SO = stuck ? 1'b1 : chain[L-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Run observations.
  int busy_cycles, loop_cycles, se_low_cnt, se_low_a, se_low_b;
  bit mode_seen, timed_out;

  task automatic start_run(input int n);
    @(negedge clk);
    sif.NUM_PAT = 8'(n);
    sif.START   = 1'b1;
    @(negedge clk);
    sif.START   = 1'b0;
  endtask

  // Starts a run, then samples at each falling edge until DONE. Optionally
  // pulses START while the run is busy.
  task automatic do_run(input int n, input int pulse_at);
    busy_cycles = 0; loop_cycles = 0; se_low_cnt = 0;
    se_low_a = -1; se_low_b = -1; mode_seen = 0; timed_out = 0;
    start_run(n);
    while (!sif.DONE) begin
      if (sif.BUSY) begin
        busy_cycles++;
        if (!sif.TEST_SE && busy_cycles > 1) begin
          se_low_cnt++;
          if (se_low_a < 0) se_low_a = busy_cycles;
          else if (se_low_b < 0) se_low_b = busy_cycles;
        end
      end
      if (sif.TEST_MODE) mode_seen = 1;
      sif.START = (pulse_at > 0 && busy_cycles == pulse_at);
      loop_cycles++;
      if (loop_cycles > 5000) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
    end
    sif.START = 1'b0;
    check("run_timeout", timed_out, 0);
  endtask

  initial begin
    int guard;
    sif.START = 1'b0; sif.ABORT = 1'b0; sif.NUM_PAT = '0;
    #12;
    check("rst_busy_done", {sif.BUSY, sif.DONE, sif.FAIL}, 0);
    check("rst_scan", {sif.TEST_MODE, sif.TEST_SE, sif.TEST_SI}, 0);
    check("rst_idx", {sif.LD_PAT_IDX, sif.UL_PAT_IDX, sif.BIT_IDX}, 0);
    check("rst_err", {sif.ERR_COUNT, sif.FIRST_FAIL_PAT}, 0);
    @(negedge clk); rst = 1'b0;

    // Assert reset asynchronously in the middle of a shift.
    start_run(2);
    guard = 0; busy_cycles = 0;
    while (busy_cycles < 10 && guard < 100) begin
      if (sif.BUSY) busy_cycles++;
      guard++;
      if (busy_cycles < 10) @(negedge clk);
    end
    check("midrst_reached", busy_cycles, 10);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {sif.BUSY, sif.DONE, sif.TEST_MODE, sif.TEST_SE}, 0);
    check("midrst_idx", {sif.LD_PAT_IDX, sif.UL_PAT_IDX, sif.BIT_IDX}, 0);
    @(negedge clk); rst = 1'b0;

    // Golden run with 2 patterns.
    do_run(2, 0);
    check("n2_busy_cycles", busy_cycles, 93);
    check("n2_done_fail", {sif.DONE, sif.FAIL}, 2'b10);
    check("n2_err", sif.ERR_COUNT, 0);
    check("n2_se_low_cnt", se_low_cnt, 2);
    check("n2_se_low_a", se_low_a, 32);
    check("n2_se_low_b", se_low_b, 63);

    // One flipped expected bit, at pattern 1 bit 7.
    flip_en = 1; flip_pat = 8'd1; flip_bit = 5'd7;
    do_run(3, 0);
    check("flip_busy_cycles", busy_cycles, 124);
    check("flip_fail", sif.FAIL, 1);
    check("flip_err", sif.ERR_COUNT, 1);
    check("flip_first", sif.FIRST_FAIL_PAT, 1);

    // The same flip with the bit masked. A new START also clears the old status.
    mask_en = 1;
    do_run(3, 0);
    check("mask_fail", sif.FAIL, 0);
    check("mask_err", sif.ERR_COUNT, 0);
    check("mask_first", sif.FIRST_FAIL_PAT, 0);
    mask_en = 0; flip_en = 0;

    // TEST_SO stuck at 1, with all-zero expected responses.
    stuck = 1;
    do_run(20, 0);
    check("stuck_busy_cycles", busy_cycles, 651);
    check("stuck_err_sat", sif.ERR_COUNT, 255);
    check("stuck_first", sif.FIRST_FAIL_PAT, 0);
    check("stuck_fail", sif.FAIL, 1);
    stuck = 0;

    // Zero-pattern run.
    do_run(0, 0);
    check("n0_loops", loop_cycles, 1);
    check("n0_busy_cycles", busy_cycles, 1);
    check("n0_mode_seen", mode_seen, 0);
    check("n0_done_fail", {sif.DONE, sif.FAIL}, 2'b10);

    // A START pulse while busy is ignored.
    do_run(3, 40);
    check("startbusy_cycles", busy_cycles, 124);
    check("startbusy_fail", sif.FAIL, 0);

    // Abort during the capture of pattern 1, after a miscompare in pattern 0.
    flip_en = 1; flip_pat = 8'd0; flip_bit = 5'd3;
    start_run(3);
    guard = 0;
    while (!(sif.BUSY && sif.TEST_MODE && !sif.TEST_SE && sif.LD_PAT_IDX == 8'd1) && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("abort_reached", guard < 200, 1);
    sif.ABORT = 1'b1;
    @(negedge clk);
    sif.ABORT = 1'b0;
    check("abort_ctrl", {sif.BUSY, sif.DONE, sif.TEST_MODE, sif.TEST_SE}, 0);
    check("abort_status", {sif.FAIL, sif.ERR_COUNT}, {1'b1, 8'd1});
    repeat (3) @(negedge clk);
    check("abort_idle", {sif.BUSY, sif.DONE, sif.TEST_MODE}, 0);
    flip_en = 0;
    do_run(3, 0);
    check("rerun_busy_cycles", busy_cycles, 124);
    check("rerun_status", {sif.DONE, sif.FAIL, sif.ERR_COUNT}, {2'b10, 8'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
